// File: rtl/vram_arb_pkg.sv
// Shared types for the video-memory arbiter: requester tags and FSM states.
package vram_arb_pkg;

    // Identifies which requester issued a memory access.
    typedef enum logic {
        TAG_VID  = 1'b0,
        TAG_HOST = 1'b1
    } tag_t;

    // Arbiter FSM: IDLE picks a winner, ISSUE holds mem_req until mem_ack.
    typedef enum logic {
        IDLE  = 1'b0,
        ISSUE = 1'b1
    } state_t;

endpackage : vram_arb_pkg

// File: rtl/vram_tag_fifo.sv
// In-order tag FIFO recording which requester owns each outstanding read.
// Ports:
//   clk, rst_n   clock, asynchronous active-low reset
//   push         write push_tag (accepted when not full, or when popping too)
//   push_tag     tag to store
//   pop          remove the head entry (ignored when empty)
//   head_tag_c   current head entry, combinational view of storage
//   full, empty  registered occupancy flags
module vram_tag_fifo
    import vram_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push,
    input  tag_t push_tag,
    input  logic pop,
    output tag_t head_tag_c,
    output logic full,
    output logic empty
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_d;
    tag_t             mem [DEPTH];
    logic             do_push;
    logic             do_pop;

    // A pop frees a slot in the same cycle, so push-while-full is legal alongside a pop.
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    assign head_tag_c = mem[rd_ptr];

    // Next occupancy; a simultaneous push and pop leaves it unchanged.
    always_comb begin : count_next
        count_d = count;
        if (do_push && !do_pop) begin
            count_d = count + CNT_W'(1);
        end else if (do_pop && !do_push) begin
            count_d = count - CNT_W'(1);
        end
    end

    // Storage, pointers and flags.
    always_ff @(posedge clk or negedge rst_n) begin : fifo_regs
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            full   <= 1'b0;
            empty  <= 1'b1;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= TAG_VID;
            end
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_tag;
                wr_ptr      <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            count <= count_d;
            full  <= (count_d == CNT_W'(DEPTH));
            empty <= (count_d == '0);
        end
    end

endmodule : vram_tag_fifo

// File: rtl/vram_arbiter.sv
// Single-port video-memory arbiter: video scan-out fetch has priority, the
// JTAG host bridge is guaranteed service by a starvation counter. Reads are
// returned in order and routed back to their requester via a tag FIFO.
// Ports:
//   clk, reset_in                         clock, asynchronous active-low reset
//   vid_req/vid_addr                      video read request (held until vid_ack)
//   vid_ack, vid_rvalid, vid_rdata        video accept pulse and read return
//   host_req/host_we/host_addr/host_wdata host request (held until host_ack)
//   host_ack, host_rvalid, host_rdata     host accept pulse and read return
//   mem_req/mem_we/mem_addr/mem_wdata     memory request, held until mem_ack
//   mem_ack, mem_rvalid, mem_rdata        memory accept and in-order read return
//   err_unexpected                        sticky: read data with nothing outstanding
module vram_arbiter
    import vram_arb_pkg::*;
#(
    parameter int unsigned ADDR_WIDTH      = 22,
    parameter int unsigned DATA_WIDTH      = 16,
    parameter int unsigned STARVE_LIMIT    = 4,
    parameter int unsigned MAX_OUTSTANDING = 4
) (
    input  logic                  clk,
    input  logic                  reset_in,
    input  logic                  vid_req,
    input  logic [ADDR_WIDTH-1:0] vid_addr,
    output logic                  vid_ack,
    output logic                  vid_rvalid,
    output logic [DATA_WIDTH-1:0] vid_rdata,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [DATA_WIDTH-1:0] host_wdata,
    output logic                  host_ack,
    output logic                  host_rvalid,
    output logic [DATA_WIDTH-1:0] host_rdata,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic                  mem_ack,
    input  logic                  mem_rvalid,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic                  err_unexpected
);

    localparam int unsigned         STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    state_t                state_q;
    state_t                state_d;
    tag_t                  grant_q;
    tag_t                  grant_d;
    logic                  we_q;
    logic                  we_d;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [ADDR_WIDTH-1:0] addr_d;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [DATA_WIDTH-1:0] wdata_d;
    logic [STARVE_W-1:0]   starve_q;
    logic [STARVE_W-1:0]   starve_d;
    logic                  err_q;
    logic                  err_d;

    logic                  vid_elig;
    logic                  host_elig;
    logic                  host_wins;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  fifo_full;
    logic                  fifo_empty;
    tag_t                  fifo_head;

    // Outstanding-read tags, in issue order.
    vram_tag_fifo #(
        .DEPTH(MAX_OUTSTANDING)
    ) u_tag_fifo (
        .clk        (clk),
        .rst_n      (reset_in),
        .push       (fifo_push),
        .push_tag   (grant_q),
        .pop        (fifo_pop),
        .head_tag_c (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty)
    );

    // Next-state, arbitration and starvation-counter logic.
    always_comb begin : arb_fsm
        state_d   = state_q;
        grant_d   = grant_q;
        we_d      = we_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        starve_d  = starve_q;
        fifo_push = 1'b0;

        // Reads need a free tag slot; writes never produce a return.
        vid_elig  = vid_req & ~fifo_full;
        host_elig = host_req & (host_we | ~fifo_full);
        host_wins = host_elig & (~vid_elig | (starve_q == STARVE_MAX));

        // The host is only "waiting" while it holds its request.
        if (!host_req) begin
            starve_d = '0;
        end

        case (state_q)
            IDLE: begin
                if (host_wins) begin
                    state_d  = ISSUE;
                    grant_d  = TAG_HOST;
                    we_d     = host_we;
                    addr_d   = host_addr;
                    wdata_d  = host_wdata;
                    starve_d = '0;
                end else if (vid_elig) begin
                    state_d = ISSUE;
                    grant_d = TAG_VID;
                    we_d    = 1'b0;
                    addr_d  = vid_addr;
                    wdata_d = '0;
                    if (host_req && (starve_q != STARVE_MAX)) begin
                        starve_d = starve_q + STARVE_W'(1);
                    end
                end
            end
            ISSUE: begin
                if (mem_ack) begin
                    state_d   = IDLE;
                    fifo_push = ~we_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        err_d = err_q | (mem_rvalid & fifo_empty);
    end

    // State and request registers.
    always_ff @(posedge clk or negedge reset_in) begin : arb_regs
        if (!reset_in) begin
            state_q  <= IDLE;
            grant_q  <= TAG_VID;
            we_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            starve_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            grant_q  <= grant_d;
            we_q     <= we_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            starve_q <= starve_d;
            err_q    <= err_d;
        end
    end

    // Memory side is driven straight from the registers.
    assign mem_req        = (state_q == ISSUE);
    assign mem_we         = we_q;
    assign mem_addr       = addr_q;
    assign mem_wdata      = wdata_q;
    assign err_unexpected = err_q;

    // Accept pulses follow mem_ack in the same cycle.
    assign vid_ack  = mem_req & mem_ack & (grant_q == TAG_VID);
    assign host_ack = mem_req & mem_ack & (grant_q == TAG_HOST);

    // Read return: route by FIFO head; data is zero when not valid so idle outputs stay 0.
    assign fifo_pop    = mem_rvalid & ~fifo_empty;
    assign vid_rvalid  = fifo_pop & (fifo_head == TAG_VID);
    assign host_rvalid = fifo_pop & (fifo_head == TAG_HOST);
    assign vid_rdata   = vid_rvalid  ? mem_rdata : '0;
    assign host_rdata  = host_rvalid ? mem_rdata : '0;

endmodule : vram_arbiter

// File: tb/tb_vram_arbiter.sv
// Self-checking bench for vram_arbiter: per-cycle vector table plus hand
// sequences for starvation, outstanding limit, FIFO full push/pop and reset.
module tb_vram_arbiter;
    import vram_arb_pkg::*;

    logic        clk = 1'b0;
    logic        reset_in = 1'b0;
    logic        vid_req, host_req, host_we;
    logic [21:0] vid_addr, host_addr;
    logic [15:0] host_wdata;
    logic        vid_ack, vid_rvalid, host_ack, host_rvalid;
    logic [15:0] vid_rdata, host_rdata;
    logic        mem_req, mem_we, mem_ack, mem_rvalid, err_unexpected;
    logic [21:0] mem_addr;
    logic [15:0] mem_wdata, mem_rdata;

    logic f_push, f_pop, f_full, f_empty;
    tag_t f_tag, f_head;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    vram_arbiter #(
        .ADDR_WIDTH(22), .DATA_WIDTH(16), .STARVE_LIMIT(4), .MAX_OUTSTANDING(4)
    ) dut (
        .clk(clk), .reset_in(reset_in),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_rvalid(vid_rvalid), .vid_rdata(vid_rdata),
        .host_req(host_req), .host_we(host_we), .host_addr(host_addr),
        .host_wdata(host_wdata), .host_ack(host_ack),
        .host_rvalid(host_rvalid), .host_rdata(host_rdata),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .err_unexpected(err_unexpected)
    );

    vram_tag_fifo #(.DEPTH(4)) u_fifo (
        .clk(clk), .rst_n(reset_in), .push(f_push), .push_tag(f_tag),
        .pop(f_pop), .head_tag_c(f_head), .full(f_full), .empty(f_empty)
    );

    typedef struct {
        logic        vr;  logic [21:0] va;
        logic        hr;  logic hwe; logic [21:0] ha; logic [15:0] hwd;
        logic        ma;  logic mrv; logic [15:0] mrd;
        logic        e_req; logic e_we; logic [21:0] e_addr; logic [15:0] e_wdata;
        logic        e_vack; logic e_hack; logic [1:0] e_ret; logic e_err;
    } vec_t;

    typedef struct {
        logic        is_host;
        logic [15:0] data;
    } ret_t;

    localparam int NV = 15;
    vec_t vecs [NV];
    ret_t sb_q [$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic set_in(input logic vr, input logic [21:0] va, input logic hr,
                          input logic hwe, input logic [21:0] ha, input logic [15:0] hwd,
                          input logic ma, input logic mrv, input logic [15:0] mrd);
        vid_req = vr; vid_addr = va; host_req = hr; host_we = hwe;
        host_addr = ha; host_wdata = hwd; mem_ack = ma; mem_rvalid = mrv; mem_rdata = mrd;
    endtask

    task automatic push_ret(input logic is_host, input logic [15:0] data);
        ret_t r;
        r.is_host = is_host;
        r.data    = data;
        sb_q.push_back(r);
    endtask

    // Pair any read return seen this cycle with the scoreboard head.
    task automatic monitor();
        ret_t r;
        if (vid_rvalid && host_rvalid) begin
            check("rvalid_both", 32'(vid_rvalid & host_rvalid), 32'd0);
        end else if (vid_rvalid || host_rvalid) begin
            if (sb_q.size() == 0) begin
                check("ret_unexpected", 32'(vid_rvalid | host_rvalid), 32'd0);
            end else begin
                r = sb_q.pop_front();
                check("ret_route", 32'(host_rvalid), 32'(r.is_host));
                check("ret_data", 32'(host_rvalid ? host_rdata : vid_rdata), 32'(r.data));
            end
        end
        if (sb_q.size() != 0) begin
            check("ret_missing", 32'(sb_q.size()), 32'd0);
            sb_q.delete();
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " mem_req"}, 32'(mem_req), 0);
        check({tag, " mem_we"}, 32'(mem_we), 0);
        check({tag, " mem_addr"}, 32'(mem_addr), 0);
        check({tag, " mem_wdata"}, 32'(mem_wdata), 0);
        check({tag, " acks"}, 32'({vid_ack, host_ack}), 0);
        check({tag, " rvalids"}, 32'({vid_rvalid, host_rvalid}), 0);
        check({tag, " rdata"}, {vid_rdata, host_rdata}, 0);
        check({tag, " err"}, 32'(err_unexpected), 0);
    endtask

    initial begin
        int    cnt;
        int    vacks;
        int    low_bad;
        logic  prev_vid;
        logic  exp_host;
        tag_t  exp_heads [4];

        // Fields: vr va hr hwe ha hwd ma mrv mrd | req we addr wdata vack hack ret err
        vecs[0]  = '{1'b0, 22'h0,   1'b1, 1'b1, 22'h10,  16'hBEEF, 1'b0, 1'b0, 16'h0,
                     1'b0, 1'b0, 22'h0,   16'h0,    1'b0, 1'b0, 2'd0, 1'b0};
        vecs[1]  = '{1'b0, 22'h0,   1'b1, 1'b1, 22'h10,  16'hBEEF, 1'b1, 1'b0, 16'h0,
                     1'b1, 1'b1, 22'h10,  16'hBEEF, 1'b0, 1'b1, 2'd0, 1'b0};
        vecs[2]  = '{1'b0, 22'h0,   1'b1, 1'b0, 22'h10,  16'h0,    1'b0, 1'b0, 16'h0,
                     1'b0, 1'b0, 22'h0,   16'h0,    1'b0, 1'b0, 2'd0, 1'b0};
        vecs[3]  = '{1'b0, 22'h0,   1'b1, 1'b0, 22'h10,  16'h0,    1'b1, 1'b0, 16'h0,
                     1'b1, 1'b0, 22'h10,  16'h0,    1'b0, 1'b1, 2'd0, 1'b0};
        vecs[4]  = '{1'b0, 22'h0,   1'b0, 1'b0, 22'h0,   16'h0,    1'b0, 1'b1, 16'hBEEF,
                     1'b0, 1'b0, 22'h0,   16'h0,    1'b0, 1'b0, 2'd2, 1'b0};
        vecs[5]  = '{1'b0, 22'h0,   1'b0, 1'b0, 22'h0,   16'h0,    1'b0, 1'b0, 16'h0,
                     1'b0, 1'b0, 22'h0,   16'h0,    1'b0, 1'b0, 2'd0, 1'b0};
        vecs[6]  = '{1'b1, 22'h100, 1'b0, 1'b0, 22'h0,   16'h0,    1'b0, 1'b0, 16'h0,
                     1'b0, 1'b0, 22'h0,   16'h0,    1'b0, 1'b0, 2'd0, 1'b0};
        vecs[7]  = '{1'b1, 22'h100, 1'b0, 1'b0, 22'h0,   16'h0,    1'b1, 1'b0, 16'h0,
                     1'b1, 1'b0, 22'h100, 16'h0,    1'b1, 1'b0, 2'd0, 1'b0};
        vecs[8]  = '{1'b0, 22'h0,   1'b1, 1'b0, 22'h200, 16'h0,    1'b0, 1'b0, 16'h0,
                     1'b0, 1'b0, 22'h0,   16'h0,    1'b0, 1'b0, 2'd0, 1'b0};
        vecs[9]  = '{1'b0, 22'h0,   1'b1, 1'b0, 22'h200, 16'h0,    1'b1, 1'b0, 16'h0,
                     1'b1, 1'b0, 22'h200, 16'h0,    1'b0, 1'b1, 2'd0, 1'b0};
        vecs[10] = '{1'b1, 22'h300, 1'b0, 1'b0, 22'h0,   16'h0,    1'b0, 1'b1, 16'h1111,
                     1'b0, 1'b0, 22'h0,   16'h0,    1'b0, 1'b0, 2'd1, 1'b0};
        vecs[11] = '{1'b1, 22'h300, 1'b0, 1'b0, 22'h0,   16'h0,    1'b1, 1'b1, 16'h2222,
                     1'b1, 1'b0, 22'h300, 16'h0,    1'b1, 1'b0, 2'd2, 1'b0};
        vecs[12] = '{1'b0, 22'h0,   1'b0, 1'b0, 22'h0,   16'h0,    1'b0, 1'b1, 16'h3333,
                     1'b0, 1'b0, 22'h0,   16'h0,    1'b0, 1'b0, 2'd1, 1'b0};
        vecs[13] = '{1'b0, 22'h0,   1'b0, 1'b0, 22'h0,   16'h0,    1'b0, 1'b1, 16'h4444,
                     1'b0, 1'b0, 22'h0,   16'h0,    1'b0, 1'b0, 2'd0, 1'b0};
        vecs[14] = '{1'b0, 22'h0,   1'b0, 1'b0, 22'h0,   16'h0,    1'b0, 1'b0, 16'h0,
                     1'b0, 1'b0, 22'h0,   16'h0,    1'b0, 1'b0, 2'd0, 1'b1};

        // Reset state, with memory-side inputs active to prove the gating.
        f_push = 1'b0; f_pop = 1'b0; f_tag = TAG_VID;
        set_in(1'b1, 22'h3FFFFF, 1'b1, 1'b1, 22'h3FFFFF, 16'hFFFF, 1'b1, 1'b1, 16'hFFFF);
        #12;
        check_all_zero("reset");
        @(negedge clk);
        set_in(1'b0, 22'h0, 1'b0, 1'b0, 22'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        reset_in = 1'b1;

        // Tag FIFO: fill, then push+pop at full must keep it full with order intact.
        exp_heads[0] = TAG_VID;  exp_heads[1] = TAG_HOST;
        exp_heads[2] = TAG_VID;  exp_heads[3] = TAG_VID;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            f_push = 1'b1;
            f_tag  = (i % 2 == 0) ? TAG_HOST : TAG_VID;
        end
        @(negedge clk);
        f_push = 1'b1; f_pop = 1'b1; f_tag = TAG_VID;
        #1;
        check("fifo full before pushpop", 32'(f_full), 1);
        check("fifo head before pushpop", 32'(f_head), 32'(TAG_HOST));
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            f_push = 1'b0; f_pop = 1'b1;
            #1;
            check($sformatf("fifo full after pushpop %0d", i), 32'(f_full), (i == 0) ? 1 : 0);
            check($sformatf("fifo empty %0d", i), 32'(f_empty), 0);
            check($sformatf("fifo head %0d", i), 32'(f_head), 32'(exp_heads[i]));
        end
        @(negedge clk);
        f_pop = 1'b0;
        #1;
        check("fifo empty after drain", 32'(f_empty), 1);

        // Table: host write/read, interleaved V/H/V returns, unexpected rvalid.
        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            set_in(vecs[i].vr, vecs[i].va, vecs[i].hr, vecs[i].hwe, vecs[i].ha,
                   vecs[i].hwd, vecs[i].ma, vecs[i].mrv, vecs[i].mrd);
            if (vecs[i].e_ret != 2'd0) push_ret(vecs[i].e_ret == 2'd2, vecs[i].mrd);
            #1;
            monitor();
            check($sformatf("v%0d mem_req", i), 32'(mem_req), 32'(vecs[i].e_req));
            if (vecs[i].e_req) begin
                check($sformatf("v%0d mem_we", i), 32'(mem_we), 32'(vecs[i].e_we));
                check($sformatf("v%0d mem_addr", i), 32'(mem_addr), 32'(vecs[i].e_addr));
                if (vecs[i].e_we)
                    check($sformatf("v%0d mem_wdata", i), 32'(mem_wdata), 32'(vecs[i].e_wdata));
            end
            check($sformatf("v%0d vid_ack", i), 32'(vid_ack), 32'(vecs[i].e_vack));
            check($sformatf("v%0d host_ack", i), 32'(host_ack), 32'(vecs[i].e_hack));
            check($sformatf("v%0d err", i), 32'(err_unexpected), 32'(vecs[i].e_err));
        end

        // Starvation guard: both requesting continuously, expect V V V V H repeating.
        cnt = 0;
        prev_vid = 1'b0;
        for (int g = 0; g < 10; g++) begin
            exp_host = (cnt == 4);
            @(negedge clk);
            set_in(1'b1, 22'(22'h1000 + g), 1'b1, 1'b1, 22'(22'h2000 + g),
                   16'(16'h7000 + g), 1'b0, prev_vid, 16'(16'hA000 + g));
            if (prev_vid) push_ret(1'b0, 16'(16'hA000 + g));
            #1;
            monitor();
            check($sformatf("starve g%0d idle mem_req", g), 32'(mem_req), 0);
            @(negedge clk);
            set_in(1'b1, 22'(22'h1000 + g), 1'b1, 1'b1, 22'(22'h2000 + g),
                   16'(16'h7000 + g), 1'b1, 1'b0, 16'h0);
            #1;
            monitor();
            check($sformatf("starve g%0d host_ack", g), 32'(host_ack), 32'(exp_host));
            check($sformatf("starve g%0d vid_ack", g), 32'(vid_ack), 32'(!exp_host));
            if (exp_host) cnt = 0;
            else if (cnt < 4) cnt++;
            prev_vid = !exp_host;
        end
        check("err sticky", 32'(err_unexpected), 1);

        // Outstanding limit: no returns, memory acks whenever requested.
        vacks = 0;
        low_bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            set_in(1'b1, 22'h3000, 1'b0, 1'b0, 22'h0, 16'h0, mem_req, 1'b0, 16'h0);
            #1;
            monitor();
            if (vid_ack) vacks++;
            if (c >= 8 && mem_req) low_bad++;
        end
        check("outst vid_acks", 32'(vacks), 4);
        check("outst mem_req low", 32'(low_bad), 0);

        // A host write still goes through while reads are blocked.
        @(negedge clk);
        set_in(1'b1, 22'h3000, 1'b1, 1'b1, 22'h40, 16'h1234, 1'b0, 1'b0, 16'h0);
        #1;
        monitor();
        check("hw idle mem_req", 32'(mem_req), 0);
        @(negedge clk);
        set_in(1'b1, 22'h3000, 1'b1, 1'b1, 22'h40, 16'h1234, 1'b1, 1'b0, 16'h0);
        #1;
        monitor();
        check("hw mem_req", 32'(mem_req), 1);
        check("hw mem_we", 32'(mem_we), 1);
        check("hw mem_addr", 32'(mem_addr), 32'h40);
        check("hw mem_wdata", 32'(mem_wdata), 32'h1234);
        check("hw acks", 32'({vid_ack, host_ack}), 32'b01);

        // One return frees exactly one read slot.
        @(negedge clk);
        set_in(1'b1, 22'h3000, 1'b0, 1'b0, 22'h0, 16'h0, 1'b0, 1'b1, 16'h5550);
        push_ret(1'b0, 16'h5550);
        #1;
        monitor();
        vacks = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            set_in(1'b1, 22'h3000, 1'b0, 1'b0, 22'h0, 16'h0, mem_req, 1'b0, 16'h0);
            #1;
            monitor();
            if (vid_ack) vacks++;
        end
        check("one rvalid one read", 32'(vacks), 1);

        // Drain the four outstanding video reads.
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            set_in(1'b0, 22'h0, 1'b0, 1'b0, 22'h0, 16'h0, 1'b0, 1'b1, 16'(16'hB000 + k));
            push_ret(1'b0, 16'(16'hB000 + k));
            #1;
            monitor();
        end
        @(negedge clk);
        set_in(1'b0, 22'h0, 1'b0, 1'b0, 22'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        #1;
        check("err still set", 32'(err_unexpected), 1);

        // Reset asserted while mem_req is high.
        @(negedge clk);
        set_in(1'b1, 22'h2ABCD, 1'b0, 1'b0, 22'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        #1;
        monitor();
        @(negedge clk);
        #1;
        check("rst pre mem_req", 32'(mem_req), 1);
        #2;
        reset_in = 1'b0;
        mem_ack = 1'b1; mem_rvalid = 1'b1; mem_rdata = 16'hDEAD;
        #1;
        check_all_zero("midrst");
        @(negedge clk);
        set_in(1'b0, 22'h0, 1'b0, 1'b0, 22'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        reset_in = 1'b1;

        // Fresh request after reset issues normally.
        @(negedge clk);
        set_in(1'b1, 22'h155, 1'b0, 1'b0, 22'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        #1;
        monitor();
        check("post idle mem_req", 32'(mem_req), 0);
        @(negedge clk);
        set_in(1'b1, 22'h155, 1'b0, 1'b0, 22'h0, 16'h0, 1'b1, 1'b0, 16'h0);
        #1;
        monitor();
        check("post mem_req", 32'(mem_req), 1);
        check("post mem_addr", 32'(mem_addr), 32'h155);
        check("post vid_ack", 32'(vid_ack), 1);
        @(negedge clk);
        set_in(1'b0, 22'h0, 1'b0, 1'b0, 22'h0, 16'h0, 1'b0, 1'b1, 16'hC0DE);
        push_ret(1'b0, 16'hC0DE);
        #1;
        monitor();
        @(negedge clk);
        set_in(1'b0, 22'h0, 1'b0, 1'b0, 22'h0, 16'h0, 1'b0, 1'b0, 16'h0);
        #1;
        check("post err clear", 32'(err_unexpected), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule : tb_vram_arbiter

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video-memory arbiter for the jtagdemo core. It shares one memory port between two requesters: the scan-out pixel fetcher, which gets priority because it has a display deadline, and the JTAG host bridge, which does debug reads and writes. Read data is returned in order and routed back to whichever requester issued the read. A starvation guard ensures the host is eventually served even under continuous video demand.

## Interface
Parameters:
- ADDR_WIDTH, 22, word address width
- DATA_WIDTH, 16, data word width
- STARVE_LIMIT, 4, consecutive video grants allowed while host waits (≥1)
- MAX_OUTSTANDING, 4, in-flight reads tracked (power of 2, ≥2)

Ports:
- clk  in  1  system clock; the block has a single clock
- reset_in  in  1  asynchronous, active-low reset
- vid_req  in  1  video read request; held until vid_ack
- vid_addr  in  ADDR_WIDTH  video read address; stable while vid_req is high
- vid_ack  out  1  one-cycle pulse: video request accepted
- vid_rvalid  out  1  one-cycle pulse: vid_rdata is valid
- vid_rdata  out  DATA_WIDTH  video read data
- host_req  in  1  host request; held until host_ack
- host_we  in  1  1 = write, 0 = read; stable with host_req
- host_addr  in  ADDR_WIDTH  host address
- host_wdata  in  DATA_WIDTH  host write data
- host_ack  out  1  one-cycle pulse: host request accepted
- host_rvalid  out  1  one-cycle pulse: host_rdata is valid
- host_rdata  out  DATA_WIDTH  host read data
- mem_req  out  1  memory request; held until mem_ack
- mem_we  out  1  memory write enable
- mem_addr  out  ADDR_WIDTH  memory address
- mem_wdata  out  DATA_WIDTH  memory write data
- mem_ack  in  1  one-cycle pulse: memory accepted the request
- mem_rvalid  in  1  read data valid; returns are in order, at any latency ≥1 cycle after mem_ack
- mem_rdata  in  DATA_WIDTH  memory read data
- err_unexpected  out  1  sticky flag: mem_rvalid arrived with no read outstanding

## Operation
- FSM states are IDLE and ISSUE.
- IDLE: evaluate requests and latch the winner's we/addr/wdata and tag into registers. Then move to ISSUE with mem_req=1 on the next cycle. If nothing is eligible, stay in IDLE.
- Eligibility: a read is eligible only if the tag FIFO is not full. Writes are always eligible.
- Priority when both requesters are eligible:
  - If starve_cnt == STARVE_LIMIT, the host wins.
  - Otherwise the video requester wins.
- starve_cnt:
  - Increments (saturating at STARVE_LIMIT) on each video grant made while host_req=1.
  - Clears on a host grant, and in any cycle where host_req=0.
- ISSUE: mem_req and its fields are held constant until mem_ack. On mem_ack:
  - The granted requester's ack is driven high combinationally in the same cycle (xxx_ack = mem_ack & grant).
  - If the access is a read, its tag is pushed into the FIFO.
  - The FSM returns to IDLE.
- Read return: on mem_rvalid, pop the FIFO head tag and assert that requester's rvalid with rdata = mem_rdata, combinationally in the same cycle. The other requester's rvalid stays 0.
- mem_rvalid with an empty FIFO: the data is dropped, no rvalid is asserted, and err_unexpected is set.
- A FIFO push and pop in the same cycle leave the occupancy unchanged. This is legal even when the FIFO is full.
- mem_wdata is don't-care on reads. It is driven with the registered value so there is no X-propagation.

## Timing
- Reset values: every output is 0, including mem_req, all acks, all rvalids, rdata, and err_unexpected. FSM = IDLE, starve_cnt = 0, FIFO empty.
- Reset asserted mid-access: mem_req drops immediately and in-flight tags are lost. Any later mem_rvalid therefore sets err_unexpected. The memory side is reset together with this block.
- Minimum issue latency is 1 cycle: req sampled in IDLE at cycle N gives mem_req=1 at cycle N+1.
- Peak throughput is one access per 2 cycles: ISSUE with immediate mem_ack, then one IDLE cycle.
- Requesters may drop req, or present a new request, in the cycle after ack.
- Read data returns to the requester in the same cycle as mem_rvalid, with no added latency.

## Structure
- Package vram_arb_pkg:
  - tag_t enum {TAG_VID, TAG_HOST}
  - state_t enum {IDLE, ISSUE}
- Sub-module vram_tag_fifo: synchronous FIFO of tag_t, depth MAX_OUTSTANDING, with full/empty flags, async active-low reset, and simultaneous push/pop support.
- The top level holds the FSM, the starvation counter, the request registers, and the rdata routing.

## Test plan
- Host-only traffic, mem_ack immediate: host write to 0x000010 (0xBEEF) is followed by a read of 0x000010. Required: host_ack pulses twice; read returning 0xBEEF gives host_rvalid=1 and vid_rvalid=0.
- Starvation guard: vid_req and host_req held high continuously with STARVE_LIMIT=4. Required grant order: V V V V H V V V V H …; starve_cnt never exceeds 4.
- Outstanding limit: mem_rvalid withheld while video issues reads. Required: exactly 4 vid_acks, then mem_req stays 0 for reads. A pending host write is still granted. One mem_rvalid re-enables exactly one read.
- Interleaved return: reads issued in order V, H, V; returns carry 0x1111, 0x2222, 0x3333. Required: vid gets 0x1111 then 0x3333; host gets 0x2222.
- Boundaries:
  - A push and pop in the same cycle at full occupancy leaves the count at 4.
  - mem_rvalid with an empty FIFO sets err_unexpected, and it stays set until reset.
- Reset mid-ISSUE: reset_in driven low while mem_req=1. Required: all outputs go to 0 asynchronously; after release the FSM is IDLE and a new request issues normally.
